// File: rtl/acquisition_controller.sv
// acquisition_controller
// Sequences one oscilloscope capture around an external edge-trigger latch:
// fills the circular sample buffer with pre-trigger history, arms the latch,
// records the trigger position, captures post-trigger samples, then holds the
// buffer for readout until Ack.
//
// Ports
//   Clock, Reset        rising-edge clock, synchronous active-high reset
//   Start, Abort        begin a capture (IDLE only) / cancel from any state
//   Continuous          re-arm automatically after Ack
//   SampleEn            one-cycle sample strobe; writes and counts only on it
//   PreSamples          pre-trigger samples to capture before arming
//   PostSamples         samples to capture after the trigger
//   Trig                trigger-latch output, asynchronous to Clock
//   Ack                 readout finished with the buffer
//   TrigReset           drives the trigger-latch Reset (low only in ARMED)
//   WrEn, WrAddr        buffer write strobe / write address
//   TrigAddr            WrAddr captured in the trigger-detection cycle
//   Done, Busy, State   status (State: IDLE=0 PRE=1 ARMED=2 POST=3 DONE=4)
//
// Optional feature macro: ACQ_AUTOTRIG_EN
//   Adds AutoTimeout (16-bit input) and AutoTrigd (output). A non-zero
//   AutoTimeout forces the ARMED->POST transition after that many ARMED
//   cycles without a trigger and sets AutoTrigd until the next PRE entry.
//
// WrEn is the sample strobe gated by the registered state, so a write lands
// on the same edge that counts it and never leaks into IDLE/DONE.

module acquisition_controller #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Abort,
    input  logic              Continuous,
    input  logic              SampleEn,
    input  logic [ADDR_W-1:0] PreSamples,
    input  logic [ADDR_W-1:0] PostSamples,
    input  logic              Trig,
    input  logic              Ack,
`ifdef ACQ_AUTOTRIG_EN
    input  logic [15:0]       AutoTimeout,
    output logic              AutoTrigd,
`endif
    output logic              TrigReset,
    output logic              WrEn,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [ADDR_W-1:0] TrigAddr,
    output logic              Done,
    output logic              Busy,
    output logic [2:0]        State
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] pre_len;
    logic [ADDR_W-1:0] post_len;
    logic [ADDR_W-1:0] sample_cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              write;
    logic              load_len;
    logic              clr_cnt;
    logic              trig_fire;
    logic              trig_meta;
    logic              trig_sync;
    logic              auto_fire;

    // Count after the current write, one bit wider so the compare cannot wrap
    assign cnt_inc = CNT_W'(sample_cnt) + CNT_W'(1);

    assign WrEn  = write;
    assign State = 3'(state);

`ifdef ACQ_AUTOTRIG_EN
    localparam int unsigned AUTO_W  = 16;
    localparam int unsigned AUTO_CW = AUTO_W + 1;

    logic [AUTO_W-1:0] auto_cnt;

    // Fires on the last ARMED cycle of the timeout window; zero disables
    assign auto_fire = (AutoTimeout != '0) &&
                       ((AUTO_CW'(auto_cnt) + AUTO_CW'(1)) == AUTO_CW'(AutoTimeout));

    // ARMED cycle counter and auto-trigger flag
    always_ff @(posedge Clock) begin
        if (Reset) begin
            auto_cnt  <= '0;
            AutoTrigd <= 1'b0;
        end else begin
            if (state == ST_ARMED) begin
                auto_cnt <= auto_cnt + AUTO_W'(1);
            end else begin
                auto_cnt <= '0;
            end
            if (load_len) begin
                AutoTrigd <= 1'b0;
            end else if (trig_fire && !trig_sync) begin
                AutoTrigd <= 1'b1;
            end
        end
    end
`else
    assign auto_fire = 1'b0;
`endif

    // Next-state and per-cycle control strobes
    always_comb begin
        next_state = state;
        write      = 1'b0;
        load_len   = 1'b0;
        clr_cnt    = 1'b0;
        trig_fire  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (Start) begin
                    next_state = ST_PRE;
                    load_len   = 1'b1;
                    clr_cnt    = 1'b1;
                end
            end
            ST_PRE: begin
                // A zero-length phase performs no writes
                write = SampleEn && (pre_len != '0);
                if ((pre_len == '0) || (write && (cnt_inc == CNT_W'(pre_len)))) begin
                    next_state = ST_ARMED;
                end
            end
            ST_ARMED: begin
                write = SampleEn;
                if (trig_sync || auto_fire) begin
                    next_state = ST_POST;
                    clr_cnt    = 1'b1;
                    trig_fire  = 1'b1;
                end
            end
            ST_POST: begin
                write = SampleEn && (post_len != '0);
                if ((post_len == '0) || (write && (cnt_inc == CNT_W'(post_len)))) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (Ack) begin
                    if (Continuous) begin
                        next_state = ST_PRE;
                        load_len   = 1'b1;
                        clr_cnt    = 1'b1;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        // Abort overrides everything; TrigAddr and lengths are left alone
        if (Abort) begin
            next_state = ST_IDLE;
            load_len   = 1'b0;
            clr_cnt    = 1'b0;
            trig_fire  = 1'b0;
        end
    end

    // State register, registered status outputs, address and counters
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= ST_IDLE;
            pre_len    <= '0;
            post_len   <= '0;
            sample_cnt <= '0;
            WrAddr     <= '0;
            TrigAddr   <= '0;
            TrigReset  <= 1'b1;
            Done       <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            state     <= next_state;
            TrigReset <= (next_state != ST_ARMED);
            Busy      <= (next_state == ST_PRE) || (next_state == ST_ARMED) ||
                         (next_state == ST_POST);
            Done      <= (next_state == ST_DONE);
            if (write) begin
                WrAddr <= WrAddr + ADDR_W'(1);
            end
            if (load_len) begin
                pre_len  <= PreSamples;
                post_len <= PostSamples;
            end
            if (clr_cnt) begin
                sample_cnt <= '0;
            end else if (write) begin
                sample_cnt <= sample_cnt + ADDR_W'(1);
            end
            if (trig_fire) begin
                TrigAddr <= WrAddr;
            end
        end
    end

    // Two-flop trigger synchronizer, held clear while the latch is in reset
    always_ff @(posedge Clock) begin
        if (Reset || TrigReset) begin
            trig_meta <= 1'b0;
            trig_sync <= 1'b0;
        end else begin
            trig_meta <= Trig;
            trig_sync <= trig_meta;
        end
    end

endmodule
